pio_input_conditioner: RTL and testbench

PIO_INPUT_CONDITIONER -- requirements
Module: pio_input_conditioner

---
 rtl/pio_input_conditioner_pkg.sv | 18 +
 rtl/pio_input_conditioner_if.sv | 22 ++
 rtl/pio_input_conditioner_key_debouncer.sv | 69 ++++++
 rtl/pio_input_conditioner.sv | 50 +++++
 tb/tb_pio_input_conditioner.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pio_input_conditioner_pkg.sv
// pio_input_conditioner_pkg: shared debounce state, key indices and counter sizing
package pio_input_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } deb_state_e;

    localparam int KEY_RESET = 0;
    localparam int KEY_ACCUM = 1;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/pio_input_conditioner_if.sv
// pio_input_conditioner_if: board-side raw inputs and SoC-side conditioned outputs
interface pio_input_conditioner_if #(
    parameter int SW_WIDTH = 8
);
    logic [1:0]          key_n_i;
    logic [SW_WIDTH-1:0] sw_i;
    logic [SW_WIDTH-1:0] sw_o;
    logic                reset_btn_o;
    logic                accumulate_btn_o;
    logic                accumulate_pulse_o;
    logic [7:0]          press_count_o;

    modport master (
        output key_n_i, sw_i,
        input  sw_o, reset_btn_o, accumulate_btn_o, accumulate_pulse_o, press_count_o
    );

    modport slave (
        input  key_n_i, sw_i,
        output sw_o, reset_btn_o, accumulate_btn_o, accumulate_pulse_o, press_count_o
    );
endinterface

// File: rtl/pio_input_conditioner_key_debouncer.sv
// key_debouncer: synchronizes one active-low key and debounces it into a level and a press strobe
module key_debouncer
    import pio_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic level_o,
    output logic pulse_o
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    // The entry edge into WAIT_* is one stable sample; DEBOUNCE_CYCLES-1 more complete the hold.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [1:0]    sync_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q;
    logic          pressed;

    assign pressed = ~sync_q[1];
    assign level_o = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
    assign pulse_o = pulse_q;

    // Two-flop synchronizer, state, counter and press strobe; reset parks the key as released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_q == WAIT_PRESS) && (state_d == PRESSED);
        end
    end

    // Debounce transitions: any contrary sample during a WAIT_* state abandons the change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: if (pressed) begin
                state_d = WAIT_PRESS;
                cnt_d   = '0;
            end
            WAIT_PRESS: begin
                state_d = !pressed ? RELEASED : (cnt_q == LAST) ? PRESSED : WAIT_PRESS;
                cnt_d   = (!pressed || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            PRESSED: if (!pressed) begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                state_d = pressed ? PRESSED : (cnt_q == LAST) ? RELEASED : WAIT_RELEASE;
                cnt_d   = (pressed || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: synchronizes switches, debounces the two keys and counts accumulate presses
module pio_input_conditioner
    import pio_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 8
) (
    input logic                   clk,
    input logic                   reset,
    pio_input_conditioner_if.slave pio
);
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic [7:0]          press_count_q, press_count_d;
    logic                accum_pulse;
    logic                unused_reset_pulse;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_key (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (pio.key_n_i[KEY_RESET]),
        .level_o (pio.reset_btn_o),
        .pulse_o (unused_reset_pulse)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accum_key (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (pio.key_n_i[KEY_ACCUM]),
        .level_o (pio.accumulate_btn_o),
        .pulse_o (accum_pulse)
    );

    assign press_count_d          = press_count_q + {7'd0, accum_pulse};
    assign pio.sw_o               = sw_s2_q;
    assign pio.accumulate_pulse_o = accum_pulse;
    assign pio.press_count_o      = press_count_q;

    // Switch synchronizer (no debounce) and wrapping press counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            press_count_q <= '0;
        end else begin
            sw_s1_q       <= pio.sw_i;
            sw_s2_q       <= sw_s1_q;
            press_count_q <= press_count_d;
        end
    end
endmodule

// File: tb/tb_pio_input_conditioner.sv
// tb_pio_input_conditioner: directed scenarios with DEBOUNCE_CYCLES=4
module tb_pio_input_conditioner;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pio_input_conditioner_if #(.SW_WIDTH(8)) pio ();

    pio_input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .pio   (pio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pio.key_n_i = 2'b11;
        pio.sw_i = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pio.key_n_i = 2'b00;
        pio.sw_i = 8'hFF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({pio.sw_o, pio.reset_btn_o, pio.accumulate_btn_o, pio.accumulate_pulse_o, pio.press_count_o} !== 19'd0) begin
                failures++;
                $display("FAIL reset_hold edge=%0d sw_o=%h rb=%b ab=%b ap=%b cnt=%0d want all 0", e, pio.sw_o,
                         pio.reset_btn_o, pio.accumulate_btn_o, pio.accumulate_pulse_o, pio.press_count_o);
            end
        end
        pio.key_n_i = 2'b11;
        pio.sw_i = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        do_reset();
        pio.key_n_i = 2'b01;
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (pio.accumulate_btn_o !== (e >= 6) || pio.accumulate_pulse_o !== (e == 6) ||
                pio.press_count_o !== ((e >= 7) ? 8'd1 : 8'd0) || pio.reset_btn_o !== 1'b0) begin
                failures++;
                $display("FAIL press edge=%0d ab=%b ap=%b cnt=%0d rb=%b want ab=%b ap=%b cnt=%0d rb=0", e,
                         pio.accumulate_btn_o, pio.accumulate_pulse_o, pio.press_count_o, pio.reset_btn_o,
                         e >= 6, e == 6, (e >= 7) ? 1 : 0);
            end
        end
        pio.key_n_i = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (pio.accumulate_btn_o !== (e < 6) || pio.accumulate_pulse_o !== 1'b0 || pio.press_count_o !== 8'd1) begin
                failures++;
                $display("FAIL release edge=%0d ab=%b ap=%b cnt=%0d want ab=%b ap=0 cnt=1", e,
                         pio.accumulate_btn_o, pio.accumulate_pulse_o, pio.press_count_o, e < 6);
            end
        end
    endtask

    task automatic test_glitch();
        int seen_btn;
        int seen_pulse;
        seen_btn = 0;
        seen_pulse = 0;
        do_reset();
        for (int e = 0; e < 20; e++) begin
            pio.key_n_i = (e < 10 && e % 2 == 0) ? 2'b01 : 2'b11;
            tick();
            seen_btn += int'(pio.accumulate_btn_o);
            seen_pulse += int'(pio.accumulate_pulse_o);
        end
        checks++;
        if (seen_btn != 0 || seen_pulse != 0 || pio.press_count_o !== 8'd0) begin
            failures++;
            $display("FAIL glitch btn_cycles=%0d pulses=%0d cnt=%0d want 0 0 0", seen_btn, seen_pulse, pio.press_count_o);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        do_reset();
        for (int p = 1; p <= 256; p++) begin
            pio.key_n_i = 2'b01;
            for (int e = 0; e < 8; e++) begin
                tick();
                pulses += int'(pio.accumulate_pulse_o);
            end
            pio.key_n_i = 2'b11;
            for (int e = 0; e < 8; e++) begin
                tick();
                pulses += int'(pio.accumulate_pulse_o);
            end
            if (p == 255) begin
                checks++;
                if (pio.press_count_o !== 8'd255) begin
                    failures++;
                    $display("FAIL count_255 cnt=%0d want 255", pio.press_count_o);
                end
            end
        end
        checks++;
        if (pio.press_count_o !== 8'd0 || pulses != 256) begin
            failures++;
            $display("FAIL count_wrap cnt=%0d pulses=%0d want cnt=0 pulses=256", pio.press_count_o, pulses);
        end
    endtask

    task automatic test_switches();
        do_reset();
        pio.sw_i = 8'hA5;
        tick();
        checks++;
        if (pio.sw_o !== 8'h00) begin
            failures++;
            $display("FAIL sw_edge1 sw_o=%h want 00", pio.sw_o);
        end
        tick();
        checks++;
        if (pio.sw_o !== 8'hA5) begin
            failures++;
            $display("FAIL sw_edge2 sw_o=%h want a5", pio.sw_o);
        end
        pio.sw_i = 8'h5A;
        tick();
        checks++;
        if (pio.sw_o !== 8'hA5) begin
            failures++;
            $display("FAIL sw_hold sw_o=%h want a5", pio.sw_o);
        end
        tick();
        checks++;
        if (pio.sw_o !== 8'h5A) begin
            failures++;
            $display("FAIL sw_change sw_o=%h want 5a", pio.sw_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pio.key_n_i = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (pio.reset_btn_o !== (e >= 6) || pio.accumulate_btn_o !== (e >= 6) || pio.accumulate_pulse_o !== (e == 6)) begin
                failures++;
                $display("FAIL both edge=%0d rb=%b ab=%b ap=%b want rb=%b ab=%b ap=%b", e, pio.reset_btn_o,
                         pio.accumulate_btn_o, pio.accumulate_pulse_o, e >= 6, e >= 6, e == 6);
            end
        end
        pio.key_n_i = 2'b11;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        do_reset();
        pio.key_n_i = 2'b01;
        for (int e = 0; e < 5; e++) tick();
        reset = 1'b1;
        #1;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (pio.accumulate_btn_o !== 1'b0 || pio.accumulate_pulse_o !== 1'b0 || pio.press_count_o !== 8'd0) begin
                failures++;
                $display("FAIL mid_reset_hold step=%0d ab=%b ap=%b cnt=%0d want 0 0 0", e,
                         pio.accumulate_btn_o, pio.accumulate_pulse_o, pio.press_count_o);
            end
            tick();
        end
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            pulses += int'(pio.accumulate_pulse_o);
            checks++;
            if (pio.accumulate_btn_o !== (e >= 6) || pio.accumulate_pulse_o !== (e == 6)) begin
                failures++;
                $display("FAIL mid_reset_resume edge=%0d ab=%b ap=%b want ab=%b ap=%b", e,
                         pio.accumulate_btn_o, pio.accumulate_pulse_o, e >= 6, e == 6);
            end
        end
        checks++;
        if (pulses != 1 || pio.press_count_o !== 8'd1) begin
            failures++;
            $display("FAIL mid_reset_count pulses=%0d cnt=%0d want 1 1", pulses, pio.press_count_o);
        end
        pio.key_n_i = 2'b11;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        pio.key_n_i = 2'b11;
        pio.sw_i = 8'h00;
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_switches();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
